ahb_burst_packer: RTL and testbench

- Sits directly downstream of the AHB register slave, in the AHB_HCLK domain.
- Each ARM write to the data register produces a one-cycle strobe plus a 32-bit word. This block buffers those words in a FIFO and packs them into fixed-length write bursts for the HyperRAM controller's request/ack and valid/ready command port.
- Bursts default to 4 words (16 bytes).
- Exposes fill level, busy and sticky overflow back to the register block for ARM readback.

---
 rtl/ahb_burst_packer.sv | 237 +++++++++++++++++++++++
 tb/tb_ahb_burst_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_packer.sv
// Buffers AHB data-register writes in a FIFO and emits fixed-length, zero-padded write bursts
// into a ring buffer for the HyperRAM controller. Optional macro BURST_PACKER_STATS_EN adds a burst counter.
module ahb_burst_packer #(
    parameter int BURST_LEN    = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 32,
    parameter int REGION_BYTES = 65536
) (
    input  logic                              AHB_HCLK,
    input  logic                              AHB_HRESETn,
    input  logic                              wr_stb,
    input  logic [31:0]                       wr_data,
    input  logic                              flush,
    input  logic                              addr_rst,
    input  logic                              clr_ovf,
    input  logic [ADDR_W-1:0]                 base_addr,
    output logic                              mem_req,
    input  logic                              mem_ack,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              mem_wvalid,
    input  logic                              mem_wready,
    output logic [31:0]                       mem_wdata,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              busy,
    output logic                              overflow
`ifdef BURST_PACKER_STATS_EN
    ,
    output logic [31:0]                       burst_count,
    input  logic                              clr_stats
`endif
);

    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int LVL_W       = PTR_W + 1;
    localparam int BEAT_W      = $clog2(BURST_LEN);
    localparam int CNT_W       = BEAT_W + 1;
    localparam int OFF_W       = $clog2(REGION_BYTES);
    localparam int BURST_BYTES = BURST_LEN * 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [31:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [LVL_W-1:0]    level_r;
    logic [BEAT_W-1:0]   beat_r, beat_nxt_s;
    logic [CNT_W-1:0]    real_cnt_r, real_cnt_nxt_s;
    logic [OFF_W-1:0]    offset_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r, wdata_nxt_s;
    logic                mem_req_r, mem_wvalid_r, busy_r, overflow_r;
    logic                flush_pend_r, flush_pend_nxt_s, flush_clr_s;
    logic                addr_rst_pend_r, load_addr_s;
    logic                full_s, push_s, drop_s, beat_acc_s, is_real_s, pop_s, last_beat_s;

    assign full_s      = (level_r == LVL_W'(FIFO_DEPTH));
    assign push_s      = wr_stb & ~full_s;
    assign drop_s      = wr_stb & full_s;
    assign beat_acc_s  = (state_r == ST_DATA) & mem_wready;
    assign is_real_s   = ({1'b0, beat_r} < real_cnt_r);
    assign pop_s       = beat_acc_s & is_real_s;
    assign last_beat_s = beat_acc_s & (beat_r == BEAT_W'(BURST_LEN - 1));

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wvalid = mem_wvalid_r;
    assign mem_wdata  = mem_wdata_r;
    assign fifo_level = level_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

    // Burst sequencing: decide launch in IDLE, wait for ack, then stream BURST_LEN beats.
    always_comb begin
        state_nxt_s    = state_r;
        real_cnt_nxt_s = real_cnt_r;
        beat_nxt_s     = beat_r;
        load_addr_s    = 1'b0;
        flush_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                beat_nxt_s = '0;
                if (level_r >= LVL_W'(BURST_LEN)) begin
                    state_nxt_s    = ST_REQ;
                    real_cnt_nxt_s = CNT_W'(BURST_LEN);
                    load_addr_s    = 1'b1;
                end else if (flush_pend_r && (level_r != '0)) begin
                    state_nxt_s    = ST_REQ;
                    real_cnt_nxt_s = CNT_W'(level_r);
                    load_addr_s    = 1'b1;
                    flush_clr_s    = 1'b1;
                end else if (flush_pend_r) begin
                    flush_clr_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt_s = ST_DATA;
                    beat_nxt_s  = '0;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                    beat_nxt_s  = '0;
                end else if (beat_acc_s) begin
                    beat_nxt_s = beat_r + BEAT_W'(1);
                end else begin
                    beat_nxt_s = beat_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                beat_nxt_s  = '0;
            end
        endcase
    end

    // Next beat data is the new FIFO head for real beats and zero for padding, so the register only moves on acceptance.
    always_comb begin
        rd_ptr_nxt_s     = rd_ptr_r;
        wdata_nxt_s      = 32'h0;
        flush_pend_nxt_s = flush_clr_s ? 1'b0 : (flush_pend_r | flush);
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if ((state_nxt_s == ST_DATA) && ({1'b0, beat_nxt_s} < real_cnt_nxt_s)) begin
            wdata_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
        end else begin
            wdata_nxt_s = 32'h0;
        end
    end

    // FIFO storage; contents are only observable through the gated beat register.
    always_ff @(posedge AHB_HCLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, level and sticky overflow (a drop beats a simultaneous clear).
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FSM state and registered command-port outputs.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            state_r      <= ST_IDLE;
            beat_r       <= '0;
            real_cnt_r   <= '0;
            flush_pend_r <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_wvalid_r <= 1'b0;
            mem_wdata_r  <= 32'h0;
            mem_addr_r   <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            beat_r       <= beat_nxt_s;
            real_cnt_r   <= real_cnt_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
            mem_req_r    <= (state_nxt_s == ST_REQ);
            mem_wvalid_r <= (state_nxt_s == ST_DATA);
            mem_wdata_r  <= wdata_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE) | flush_pend_nxt_s;
            if (load_addr_s) begin
                mem_addr_r <= base_addr + ADDR_W'(offset_r);
            end
        end
    end

    // Ring-buffer offset; an address reset seen mid-burst is deferred to burst completion.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            offset_r        <= '0;
            addr_rst_pend_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && addr_rst) begin
                offset_r <= '0;
            end else if (last_beat_s) begin
                offset_r <= (addr_rst_pend_r | addr_rst) ? '0 : offset_r + OFF_W'(BURST_BYTES);
            end
            if (last_beat_s) begin
                addr_rst_pend_r <= 1'b0;
            end else if (addr_rst && (state_r != ST_IDLE)) begin
                addr_rst_pend_r <= 1'b1;
            end
        end
    end

`ifdef BURST_PACKER_STATS_EN
    logic [31:0] burst_count_r;
    assign burst_count = burst_count_r;

    // Completed-burst counter; clear wins over a coincident completion.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            burst_count_r <= 32'h0;
        end else if (clr_stats) begin
            burst_count_r <= 32'h0;
        end else if (last_beat_s) begin
            burst_count_r <= burst_count_r + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_burst_packer.sv
// Scoreboard bench for ahb_burst_packer with a 32-byte ring so address wrap is exercised.
module tb_ahb_burst_packer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        AHB_HCLK = 1'b0;
    logic        AHB_HRESETn = 1'b0;
    logic        wr_stb = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        flush = 1'b0;
    logic        addr_rst = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] base_addr = BASE;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wvalid;
    logic        mem_wready = 1'b1;
    logic [31:0] mem_wdata;
    logic [4:0]  fifo_level;
    logic        busy;
    logic        overflow;
`ifdef BURST_PACKER_STATS_EN
    logic [31:0] burst_count;
    logic        clr_stats = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    bit ack_en = 1'b1;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_beat_q[$];

    ahb_burst_packer #(
        .BURST_LEN(4), .FIFO_DEPTH(16), .ADDR_W(32), .REGION_BYTES(32)
    ) dut (
`ifdef BURST_PACKER_STATS_EN
        .burst_count(burst_count),
        .clr_stats(clr_stats),
`endif
        .AHB_HCLK(AHB_HCLK), .AHB_HRESETn(AHB_HRESETn),
        .wr_stb(wr_stb), .wr_data(wr_data), .flush(flush), .addr_rst(addr_rst),
        .clr_ovf(clr_ovf), .base_addr(base_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
        .fifo_level(fifo_level), .busy(busy), .overflow(overflow)
    );

    always #5 AHB_HCLK = ~AHB_HCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge AHB_HCLK);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_stb = 1'b1;
        wr_data = d;
        step();
        wr_stb = 1'b0;
    endtask

    task automatic expect_burst(input logic [31:0] addr, input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3);
        exp_addr_q.push_back(addr);
        exp_beat_q.push_back(b0);
        exp_beat_q.push_back(b1);
        exp_beat_q.push_back(b2);
        exp_beat_q.push_back(b3);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 300 && !(exp_addr_q.size() == 0 && exp_beat_q.size() == 0 && !busy)) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 64'(n >= 300), 64'd0);
    endtask

    task automatic wait_wvalid(input string name);
        int n = 0;
        while (n < 100 && !mem_wvalid) begin
            step();
            n++;
        end
        check({name, "_wvalid_timeout"}, 64'(n >= 100), 64'd0);
    endtask

    task automatic wait_beats_drained(input string name);
        int n = 0;
        while (n < 100 && exp_beat_q.size() != 0) begin
            step();
            n++;
        end
        check({name, "_drain_timeout"}, 64'(n >= 100), 64'd0);
    endtask

    // Controller model: acknowledges each request for one cycle when enabled.
    initial begin
        forever begin
            @(posedge AHB_HCLK);
            #1;
            mem_ack = ack_en && mem_req;
        end
    end

    // Monitor: compares each new request address and each accepted beat against the scoreboard.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        bit          req_seen;
        prev_stall = 1'b0;
        prev_data = 32'h0;
        req_seen = 1'b0;
        forever begin
            @(negedge AHB_HCLK);
            if (!AHB_HRESETn) begin
                prev_stall = 1'b0;
                req_seen = 1'b0;
            end else begin
                if (mem_req && !req_seen) begin
                    req_seen = 1'b1;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req actual=%0h required=none", mem_addr);
                    end else begin
                        check("burst_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                    end
                end
                if (!mem_req) req_seen = 1'b0;
                if (prev_stall && mem_wvalid) check("stall_hold", 64'(mem_wdata), 64'(prev_data));
                if (mem_wvalid && mem_wready) begin
                    if (exp_beat_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none", mem_wdata);
                    end else begin
                        check("beat_data", 64'(mem_wdata), 64'(exp_beat_q.pop_front()));
                    end
                end
                prev_stall = mem_wvalid && !mem_wready;
                prev_data = mem_wdata;
            end
        end
    end

    initial begin
        logic [3:0] bp_pat;
        bp_pat = 4'b1001;

        // Reset state
        step();
        step();
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_wvalid", 64'(mem_wvalid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        AHB_HRESETn = 1'b1;
        step();

        // Full burst at base+0
        expect_burst(BASE, 32'h11, 32'h22, 32'h33, 32'h44);
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        wait_beats_drained("full");
        check("full_level_after", 64'(fifo_level), 64'd0);
        wait_done("full");

        // Partial flush at base+0x10 with zero padding
        expect_burst(BASE + 32'h10, 32'hA, 32'hB, 32'h0, 32'h0);
        push_word(32'hA); push_word(32'hB);
        flush = 1'b1; step(); flush = 1'b0;
        wait_beats_drained("flush");
        check("flush_busy_drop", 64'(busy), 64'd0);
        wait_done("flush");

        // Flush with empty FIFO: no request, busy settles low
        flush = 1'b1; step(); flush = 1'b0;
        step(); step();
        check("empty_flush_busy", 64'(busy), 64'd0);
        check("empty_flush_req", 64'(mem_req), 64'd0);

        // Backpressure with concurrent pushes; ring wrapped to 0
        expect_burst(BASE, 32'h31, 32'h32, 32'h33, 32'h34);
        expect_burst(BASE + 32'h10, 32'h41, 32'h42, 32'h43, 32'h44);
        mem_wready = 1'b0;
        push_word(32'h31); push_word(32'h32); push_word(32'h33); push_word(32'h34);
        wait_wvalid("bp");
        for (int k = 0; k < 4; k++) begin
            mem_wready = bp_pat[3 - k];
            wr_stb = 1'b1;
            wr_data = 32'h41 + 32'(k);
            step();
        end
        wr_stb = 1'b0;
        mem_wready = 1'b1;
        wait_done("bp");

        // Overflow: controller stalls, 17 pushes
        ack_en = 1'b0;
        expect_burst(BASE, 32'h100, 32'h101, 32'h102, 32'h103);
        expect_burst(BASE + 32'h10, 32'h104, 32'h105, 32'h106, 32'h107);
        expect_burst(BASE, 32'h108, 32'h109, 32'h10A, 32'h10B);
        expect_burst(BASE + 32'h10, 32'h10C, 32'h10D, 32'h10E, 32'h10F);
        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        check("ovf_level", 64'(fifo_level), 64'd16);
        check("ovf_set", 64'(overflow), 64'd1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);
        clr_ovf = 1'b1; wr_stb = 1'b1; wr_data = 32'hDEAD; step();
        clr_ovf = 1'b0; wr_stb = 1'b0;
        check("ovf_set_wins", 64'(overflow), 64'd1);
        check("ovf_level_hold", 64'(fifo_level), 64'd16);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        ack_en = 1'b1;
        wait_done("ovf");

        // Wrap: +0, +0x10, +0; addr_rst during third burst forces fourth to +0
        expect_burst(BASE, 32'h51, 32'h52, 32'h53, 32'h54);
        push_word(32'h51); push_word(32'h52); push_word(32'h53); push_word(32'h54);
        wait_done("wrap1");
        expect_burst(BASE + 32'h10, 32'h55, 32'h56, 32'h57, 32'h58);
        push_word(32'h55); push_word(32'h56); push_word(32'h57); push_word(32'h58);
        wait_done("wrap2");
        ack_en = 1'b0;
        expect_burst(BASE, 32'h59, 32'h5A, 32'h5B, 32'h5C);
        push_word(32'h59); push_word(32'h5A); push_word(32'h5B); push_word(32'h5C);
        step(); step();
        check("wrap3_req", 64'(mem_req), 64'd1);
        addr_rst = 1'b1; step(); addr_rst = 1'b0;
        ack_en = 1'b1;
        wait_done("wrap3");
        expect_burst(BASE, 32'h5D, 32'h5E, 32'h5F, 32'h60);
        push_word(32'h5D); push_word(32'h5E); push_word(32'h5F); push_word(32'h60);
        wait_done("addr_rst_busy");
        // Offset is now 0x10; addr_rst in IDLE sends the next burst to +0
        addr_rst = 1'b1; step(); addr_rst = 1'b0;
        expect_burst(BASE, 32'h65, 32'h66, 32'h67, 32'h68);
        push_word(32'h65); push_word(32'h66); push_word(32'h67); push_word(32'h68);
        wait_done("addr_rst_idle");

        // Reset in the middle of DATA after two beats (offset 0x10 here)
        expect_burst(BASE + 32'h10, 32'h61, 32'h62, 32'h63, 32'h64);
        push_word(32'h61); push_word(32'h62); push_word(32'h63); push_word(32'h64);
        wait_wvalid("rst_mid");
        step(); step();
        AHB_HRESETn = 1'b0;
        #1;
        check("mid_rst_req", 64'(mem_req), 64'd0);
        check("mid_rst_wvalid", 64'(mem_wvalid), 64'd0);
        check("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        check("mid_rst_pending_beats", 64'(exp_beat_q.size()), 64'd2);
        exp_beat_q.delete();
        exp_addr_q.delete();
        step(); step();
        AHB_HRESETn = 1'b1;
        step();
        expect_burst(BASE, 32'h71, 32'h72, 32'h73, 32'h74);
        push_word(32'h71); push_word(32'h72); push_word(32'h73); push_word(32'h74);
        wait_done("post_rst");

        check("final_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        check("final_beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
